// File: rtl/mm_pkg.sv
// mm_pkg: shared widths, operand select codes and FSM states for the matrix-multiply sequencer
package mm_pkg;
    localparam int DATA_W = 8;
    localparam int RES_W  = 17;
    localparam int N_OPS  = 8;
    localparam int N_RES  = 4;
    localparam logic [2:0] SEL_A00 = 3'd0;
    localparam logic [2:0] SEL_A01 = 3'd1;
    localparam logic [2:0] SEL_A10 = 3'd2;
    localparam logic [2:0] SEL_A11 = 3'd3;
    localparam logic [2:0] SEL_B00 = 3'd4;
    localparam logic [2:0] SEL_B01 = 3'd5;
    localparam logic [2:0] SEL_B10 = 3'd6;
    localparam logic [2:0] SEL_B11 = 3'd7;
    typedef enum logic [1:0] {LOAD, WRITE, CAPTURE, OUT} state_t;
endpackage

// File: rtl/mm_stream_sequencer.sv
// mm_stream_sequencer: streams 8 operand bytes into the 2x2 multiply core and streams its 4 results back out
module mm_stream_sequencer
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [RES_W-1:0]  out_data,
    output logic [1:0]        out_idx,
    input  logic              out_ready,
    output logic              job_done,
    output logic [2:0]        mm_sel_in,
    output logic [DATA_W-1:0] mm_input_val,
    output logic              mm_execute,
    output logic [1:0]        mm_sel_out,
    input  logic [RES_W-1:0]  mm_result
);
    state_t state, state_next;
    logic [2:0] op_cnt;
    logic [1:0] res_idx;
    logic last_op, last_res;

    assign last_op  = op_cnt == 3'(N_OPS - 1);
    assign last_res = res_idx == 2'(N_RES - 1);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_next;
    end

    // next state and stream-side ready
    always_comb begin
        state_next = state;
        in_ready   = state == LOAD;
        case (state)
            LOAD:    state_next = (in_valid && last_op) ? WRITE : LOAD;
            WRITE:   state_next = CAPTURE;
            CAPTURE: state_next = OUT;
            OUT:     state_next = out_ready ? (last_res ? LOAD : CAPTURE) : OUT;
            default: state_next = LOAD;
        endcase
    end

    // counters, core control pins and the registered result port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_cnt       <= '0;
            res_idx      <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_idx      <= '0;
            job_done     <= 1'b0;
            mm_sel_in    <= SEL_A00;
            mm_input_val <= '0;
            mm_execute   <= 1'b1;
            mm_sel_out   <= '0;
        end else begin
            job_done <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        mm_sel_in    <= op_cnt;
                        mm_input_val <= in_data;
                        mm_execute   <= 1'b0;
                        op_cnt       <= last_op ? 3'd0 : op_cnt + 3'd1;
                    end else begin
                        mm_execute <= 1'b1;
                    end
                end
                WRITE: begin
                    mm_execute <= 1'b1;
                    mm_sel_out <= '0;
                    res_idx    <= '0;
                end
                CAPTURE: begin
                    out_data  <= mm_result;
                    out_idx   <= res_idx;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        job_done   <= last_res;
                        res_idx    <= last_res ? 2'd0 : res_idx + 2'd1;
                        mm_sel_out <= last_res ? mm_sel_out : res_idx + 2'd1;
                    end
                end
                default: mm_execute <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_mm_stream_sequencer.sv
// tb_mm_stream_sequencer: directed jobs through the sequencer with a behavioural multiply core alongside
module tb_mm_stream_sequencer;
    logic        clk, reset;
    logic        in_valid, in_ready, out_valid, out_ready, job_done, mm_execute;
    logic [7:0]  in_data, mm_input_val;
    logic [16:0] out_data, mm_result;
    logic [1:0]  out_idx, mm_sel_out;
    logic [2:0]  mm_sel_in;
    logic [7:0]  core_reg [8];
    logic [7:0]  ops [$];
    int          exps [$];
    int          errors = 0, checks = 0, cyc = 0, n_done = 0;
    int          last_acc = 0, first_rise = 0;
    logic        expect_done = 0, hs_prev, mon_on = 0;

    mm_stream_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_ready(out_ready),
        .job_done(job_done), .mm_sel_in(mm_sel_in), .mm_input_val(mm_input_val),
        .mm_execute(mm_execute), .mm_sel_out(mm_sel_out), .mm_result(mm_result)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (job_done) n_done++;

    // behavioural core: writes while execute is low, result selected combinationally
    always @(posedge clk or negedge reset) begin
        if (!reset) for (int i = 0; i < 8; i++) core_reg[i] <= 8'd0;
        else if (!mm_execute) core_reg[mm_sel_in] <= mm_input_val;
    end
    always_comb begin
        mm_result = 17'(int'(core_reg[{1'b0, mm_sel_out[1], 1'b0}]) * int'(core_reg[{2'b10, mm_sel_out[0]}])
                      + int'(core_reg[{1'b0, mm_sel_out[1], 1'b1}]) * int'(core_reg[{2'b11, mm_sel_out[0]}]));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // execute may be low only in the cycle right after an accepted byte
    always @(posedge clk or negedge reset) begin
        if (!reset) hs_prev <= 1'b0;
        else        hs_prev <= in_valid && in_ready;
    end
    always @(negedge clk) if (reset && mon_on) check("exec_rule", mm_execute, !hs_prev);

    task automatic send(input logic [7:0] b);
        int g = 0;
        in_valid = 1;
        in_data  = b;
        while (!in_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) check("in_timeout", 0, 1);
        last_acc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic produce(input bit gaps);
        foreach (ops[i]) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send(ops[i]);
        end
        in_valid = 0;
    endtask

    task automatic consume(input bit stalls);
        int k = 0, guard = 0;
        logic stalled = 0, got_first = 0;
        logic [16:0] h_data = 0;
        logic [1:0] h_idx = 0;
        while (k < exps.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
            check("job_done", job_done, expect_done);
            expect_done = 0;
            if (stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, h_data);
                check("hold_idx", out_idx, h_idx);
                stalled = 0;
            end
            out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (out_valid) begin
                if (!got_first) begin
                    first_rise = cyc;
                    got_first = 1;
                end
                check("in_ready_busy", in_ready, 0);
                if (out_ready) begin
                    check("out_data", out_data, exps[k]);
                    check("out_idx", out_idx, k % 4);
                    expect_done = (k % 4) == 3;
                    k++;
                end else begin
                    stalled = 1;
                    h_data = out_data;
                    h_idx = out_idx;
                end
            end
        end
        if (k < exps.size()) check("out_timeout", k, exps.size());
        @(negedge clk);
        check("job_done", job_done, expect_done);
        expect_done = 0;
        out_ready = 0;
    endtask

    task automatic run(input bit gaps, input bit stalls);
        fork
            produce(gaps);
            consume(stalls);
        join
    endtask

    initial begin
        reset = 1; in_valid = 0; in_data = 0; out_ready = 0;
        #2 reset = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_job_done", job_done, 0);
        check("rst_execute", mm_execute, 1);
        check("rst_sel_in", mm_sel_in, 0);
        check("rst_input_val", mm_input_val, 0);
        check("rst_sel_out", mm_sel_out, 0);
        reset = 1;
        @(negedge clk);
        mon_on = 1;

        ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        exps = '{19, 22, 43, 50};
        run(0, 0);
        check("latency", first_rise - last_acc, 2);

        ops = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        exps = '{130050, 130050, 130050, 130050};
        run(0, 0);

        ops = '{8'd2, 8'd0, 8'd0, 8'd2, 8'd9, 8'd8, 8'd7, 8'd6};
        exps = '{18, 16, 14, 12};
        run(1, 1);

        for (int i = 0; i < 5; i++) send(8'(i + 3));
        in_valid = 0;
        reset = 0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_execute", mm_execute, 1);
        reset = 1;
        @(negedge clk);
        ops = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd10, 8'd20, 8'd30, 8'd40};
        exps = '{10, 20, 30, 40};
        run(0, 0);

        ops = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd10, 8'd20, 8'd30, 8'd40,
                8'd0, 8'd1, 8'd1, 8'd0, 8'd10, 8'd20, 8'd30, 8'd40};
        exps = '{10, 20, 30, 40, 30, 40, 10, 20};
        run(0, 1);

        @(negedge clk);
        check("done_pulses", n_done, 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
